pe_tile_scheduler: RTL

Sequences one PE through a convolution layer: LOAD (DRAM fills IARAM/weight buffer), COMPUTE (streams I-activation × F-weight groups to the multiplier array) and DRAIN (PPU writes OARAM).
- Drives the state code, index/remaining counters and layer parity consumed by the I/OARAM buffer.
- Loop nest: output-channel group k (outer), input channel c, activation group a, weight group w (inner).

---
 rtl/pe_tile_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pe_tile_scheduler.sv
// pe_tile_scheduler: sequences one PE through a conv layer (LOAD -> COMPUTE -> DRAIN per channel / k group).
// Ports: clk/rst (sync, active-high); start/cfg_num_c/cfg_num_k begin a layer; load_done/load_*_cnt close a LOAD;
//        mul_ready accepts a COMPUTE beat; ppu_done closes a DRAIN; outputs are the state code, indices,
//        remaining counts/flags, beat_valid, layer_parity and a one-cycle layer_done pulse.
module pe_tile_scheduler #(
  parameter int I   = 4,
  parameter int F   = 4,
  parameter int A_W = 8,
  parameter int W_W = 6,
  parameter int C_W = 4,
  parameter int K_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [C_W-1:0] cfg_num_c,
  input  logic [K_W-1:0] cfg_num_k,
  input  logic           load_done,
  input  logic [A_W-1:0] load_act_cnt,
  input  logic [W_W-1:0] load_wt_cnt,
  input  logic           mul_ready,
  input  logic           ppu_done,
  output logic [1:0]     state,
  output logic [C_W-1:0] current_c,
  output logic [K_W-1:0] current_k,
  output logic [A_W-1:0] current_a,
  output logic [W_W-1:0] current_w,
  output logic [A_W-1:0] remain_a,
  output logic [W_W-1:0] remain_w,
  output logic           flag_remain_a,
  output logic           flag_remain_w,
  output logic           beat_valid,
  output logic           layer_parity,
  output logic           layer_done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]     r_state;
  logic [C_W-1:0] r_num_c;
  logic [K_W-1:0] r_num_k;
  logic [A_W-1:0] r_act;
  logic [W_W-1:0] r_wt;
  logic [C_W-1:0] r_c;
  logic [K_W-1:0] r_k;
  logic [A_W-1:0] r_a;
  logic [W_W-1:0] r_w;
  logic           r_parity;
  logic           r_done;

  // Sums carry one extra bit so a count near the top of the range never wraps.
  logic [A_W:0]   w_a_sum;
  logic [W_W:0]   w_w_sum;
  logic           w_a_last;
  logic           w_w_last;
  logic           w_last_c;
  logic           w_last_k;
  logic           w_zero_load;
  logic [1:0]     w_adv_state;
  logic [C_W-1:0] w_adv_c;

  assign w_a_sum     = {1'b0, r_a} + (A_W+1)'(I);
  assign w_w_sum     = {1'b0, r_w} + (W_W+1)'(F);
  assign w_a_last    = (w_a_sum >= {1'b0, r_act});
  assign w_w_last    = (w_w_sum >= {1'b0, r_wt});
  assign w_last_c    = (r_c >= r_num_c - C_W'(1));
  assign w_last_k    = (r_k >= r_num_k - K_W'(1));
  assign w_zero_load = (load_act_cnt == '0) || (load_wt_cnt == '0);

  // Channel advance is shared by the LOAD skip path and the last COMPUTE beat.
  assign w_adv_state = w_last_c ? S_DRAIN : S_LOAD;
  assign w_adv_c     = w_last_c ? r_c : r_c + C_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_num_c  <= '0;
      r_num_k  <= '0;
      r_act    <= '0;
      r_wt     <= '0;
      r_c      <= '0;
      r_k      <= '0;
      r_a      <= '0;
      r_w      <= '0;
      r_parity <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_num_c <= (cfg_num_c == '0) ? C_W'(1) : cfg_num_c;
            r_num_k <= (cfg_num_k == '0) ? K_W'(1) : cfg_num_k;
            r_c     <= '0;
            r_k     <= '0;
          end
        end
        S_LOAD: begin
          if (load_done) begin
            r_act <= load_act_cnt;
            r_wt  <= load_wt_cnt;
            r_a   <= '0;
            r_w   <= '0;
            if (w_zero_load) begin
              r_state <= w_adv_state;
              r_c     <= w_adv_c;
            end else begin
              r_state <= S_COMPUTE;
            end
          end
        end
        S_COMPUTE: begin
          if (mul_ready) begin
            if (!w_w_last) begin
              r_w <= w_w_sum[W_W-1:0];
            end else if (!w_a_last) begin
              r_w <= '0;
              r_a <= w_a_sum[A_W-1:0];
            end else begin
              // Last beat of the channel: park the beat indices at zero.
              r_a     <= '0;
              r_w     <= '0;
              r_state <= w_adv_state;
              r_c     <= w_adv_c;
            end
          end
        end
        default: begin // S_DRAIN
          if (ppu_done) begin
            if (!w_last_k) begin
              r_k     <= r_k + K_W'(1);
              r_c     <= '0;
              r_state <= S_LOAD;
            end else begin
              r_done   <= 1'b1;
              r_parity <= ~r_parity;
              r_c      <= '0;
              r_k      <= '0;
              r_state  <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign state         = r_state;
  assign current_c     = r_c;
  assign current_k     = r_k;
  assign current_a     = r_a;
  assign current_w     = r_w;
  assign remain_a      = r_act - r_a;
  assign remain_w      = r_wt - r_w;
  assign flag_remain_a = (remain_a >= A_W'(I));
  assign flag_remain_w = (remain_w >= W_W'(F));
  assign beat_valid    = (r_state == S_COMPUTE);
  assign layer_parity  = r_parity;
  assign layer_done    = r_done;

endmodule
